// File: rtl/glyph_ring_scroller_if.sv
// Word-load channel into the glyph ring: valid/ready handshake carrying one ring word.
// Bit CODE_W of wr_data selects glyph (1) or raw column (0).
interface glyph_ring_scroller_if #(
    parameter int CODE_W = 6
);
    logic              wr_valid;
    logic [CODE_W:0]   wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/glyph_ring_scroller.sv
// Scrolling-text column generator: rotates a ring of glyph/raw words and emits one
// registered display column per run cycle, using an external combinational font ROM.
module glyph_ring_scroller #(
    parameter int WORD_COUNT = 30,
    parameter int CODE_W     = 6,
    parameter int COL_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 run,
    glyph_ring_scroller_if.slave wr,
    input  logic                 under,
    input  logic                 over,
    output logic [CODE_W-1:0]    font_code,
    output logic [COL_W-1:0]     font_col,
    input  logic [CODE_W+1:0]    font_bits,
    output logic [CODE_W+1:0]    col_out,
    output logic                 col_valid,
    output logic                 frame_start
);
    localparam int WORD_W = CODE_W + 1;
    localparam int DISP_W = CODE_W + 2;
    localparam int IDX_W  = $clog2(WORD_COUNT);

    logic [WORD_W-1:0] word_q [WORD_COUNT];
    logic [WORD_W-1:0] word_d [WORD_COUNT];
    logic [COL_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DISP_W-1:0] col_out_q, col_out_d;
    logic              col_valid_q, col_valid_d;
    logic              frame_q, frame_d;
    logic              head_raw;
    logic              adv;

    assign head_raw  = !word_q[0][CODE_W];
    assign font_code = word_q[0][CODE_W-1:0];
    assign font_col  = col_q;
    // reset gates ready so no word is taken while the ring is being initialised
    assign adv       = run && !clear && !reset && (head_raw || col_q == '1);
    assign wr.wr_ready = adv;

    always_comb begin
        word_d      = word_q;
        col_d       = col_q;
        idx_d       = idx_q;
        col_out_d   = col_out_q;
        col_valid_d = 1'b0;
        frame_d     = 1'b0;
        if (clear) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                word_d[i] = '0;
            end
            col_d = '0;
            idx_d = '0;
        end else if (run) begin
            col_out_d   = head_raw ? {under, word_q[0][CODE_W-1:0], over} : font_bits;
            col_valid_d = 1'b1;
            frame_d     = (idx_q == '0) && (col_q == '0);
            if (adv) begin
                for (int i = 0; i < WORD_COUNT - 1; i++) begin
                    word_d[i] = word_q[i+1];
                end
                // an accepted load replaces the outgoing head; otherwise it recirculates
                word_d[WORD_COUNT-1] = wr.wr_valid ? wr.wr_data : word_q[0];
                col_d = '0;
                idx_d = (idx_q == IDX_W'(WORD_COUNT - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                word_q[i] <= '0;
            end
            col_q       <= '0;
            idx_q       <= '0;
            col_out_q   <= '0;
            col_valid_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            word_q      <= word_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            col_out_q   <= col_out_d;
            col_valid_q <= col_valid_d;
            frame_q     <= frame_d;
        end
    end

    assign col_out     = col_out_q;
    assign col_valid   = col_valid_q;
    assign frame_start = frame_q;
endmodule

// File: tb/tb_glyph_ring_scroller.sv
// Directed bench for glyph_ring_scroller with a queue-based ring model and output scoreboard.
module tb_glyph_ring_scroller;
    localparam int WC = 4;
    localparam int CW = 6;
    localparam int LW = 3;
    localparam int WW = CW + 1;
    localparam int DW = CW + 2;

    typedef struct {
        logic [DW-1:0] col;
        logic          fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          run = 1'b0;
    logic          under = 1'b0;
    logic          over = 1'b0;
    logic [CW-1:0] font_code;
    logic [LW-1:0] font_col;
    logic [DW-1:0] font_bits;
    logic [DW-1:0] col_out;
    logic          col_valid;
    logic          frame_start;

    glyph_ring_scroller_if #(.CODE_W(CW)) wr_if ();

    glyph_ring_scroller #(.WORD_COUNT(WC), .CODE_W(CW), .COL_W(LW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .run(run), .wr(wr_if),
        .under(under), .over(over), .font_code(font_code), .font_col(font_col),
        .font_bits(font_bits), .col_out(col_out), .col_valid(col_valid),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom(input logic [CW-1:0] c, input logic [LW-1:0] k);
        return {c, 2'b00} ^ {k, 5'b10101};
    endfunction

    assign font_bits = rom(font_code, font_col);

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_frame = -1;
    int frame_period = 0;

    logic [WW-1:0] m_ring[$];
    int            m_col;
    int            m_idx;
    logic [DW-1:0] m_out;
    bit            m_vld;
    bit            m_adv;
    exp_t          sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ring.delete();
        for (int i = 0; i < WC; i++) m_ring.push_back('0);
        m_col = 0;
        m_idx = 0;
        m_out = '0;
        m_vld = 0;
        m_adv = 0;
        sb.delete();
    endtask

    // Inputs are set before the call; checks combinational outputs, steps the model, then registered outputs.
    task automatic cycle();
        logic [WW-1:0] h;
        logic          hraw;
        exp_t          e;
        #2;
        h    = m_ring[0];
        hraw = !h[CW];
        m_adv = run && !clear && (hraw || m_col == (1 << LW) - 1);
        chk("font_code", 32'(font_code), 32'(h[CW-1:0]));
        chk("font_col", 32'(font_col), 32'(m_col));
        chk("wr_ready", 32'(wr_if.wr_ready), 32'(m_adv));
        if (clear) begin
            for (int i = 0; i < WC; i++) m_ring[i] = '0;
            m_col = 0;
            m_idx = 0;
            m_vld = 0;
        end else if (run) begin
            e.col = hraw ? {under, h[CW-1:0], over} : rom(h[CW-1:0], LW'(m_col));
            e.fs  = (m_idx == 0) && (m_col == 0);
            sb.push_back(e);
            m_vld = 1;
            if (m_adv) begin
                void'(m_ring.pop_front());
                m_ring.push_back(wr_if.wr_valid ? wr_if.wr_data : h);
                m_col = 0;
                m_idx = (m_idx + 1) % WC;
            end else begin
                m_col++;
            end
        end else begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("col_valid", 32'(col_valid), 32'(m_vld));
        if (m_vld && sb.size() > 0) begin
            e = sb.pop_front();
            m_out = e.col;
            chk("frame_start", 32'(frame_start), 32'(e.fs));
        end else begin
            chk("frame_start", 32'(frame_start), 32'(0));
        end
        chk("col_out", 32'(col_out), 32'(m_out));
        if (col_valid && frame_start) begin
            if (last_frame >= 0) frame_period = cyc - last_frame;
            last_frame = cyc;
        end
    endtask

    initial begin
        logic [WW-1:0] vals_a[4];
        logic [WW-1:0] vals_b[4];
        int loaded;
        int nca;
        vals_a = '{7'h41, 7'h42, 7'h43, 7'h44};
        vals_b = '{7'h41, 7'h25, 7'h43, 7'h26};
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;

        // reset held with run=1: everything at zero, ready low
        run = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_col_out", 32'(col_out), 32'(0));
        chk("rst_col_valid", 32'(col_valid), 32'(0));
        chk("rst_frame", 32'(frame_start), 32'(0));
        chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'(0));
        chk("rst_font_col", 32'(font_col), 32'(0));
        model_reset();
        reset = 1'b0;

        // load four glyphs on successive ready cycles
        loaded = 0;
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 20 && loaded < 4; i++) begin
            wr_if.wr_data = vals_a[loaded];
            cycle();
            if (m_adv) loaded++;
        end
        wr_if.wr_valid = 1'b0;

        // recirculate: all-glyph frame period is WC * 8
        last_frame = -1;
        frame_period = 0;
        for (int i = 0; i < 66; i++) cycle();
        chk("glyph_period", 32'(frame_period), 32'(32));

        // pause at column 3
        for (int i = 0; i < 40 && m_col != 3; i++) cycle();
        chk("pre_pause_col", 32'(font_col), 32'(3));
        run = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("pause_col", 32'(font_col), 32'(3));
        run = 1'b1;
        for (int i = 0; i < 2; i++) cycle();

        // asynchronous reset between edges while at column 5
        for (int i = 0; i < 40 && m_col != 5; i++) cycle();
        chk("pre_reset_col", 32'(font_col), 32'(5));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_col_out", 32'(col_out), 32'(0));
        chk("arst_col_valid", 32'(col_valid), 32'(0));
        chk("arst_frame", 32'(frame_start), 32'(0));
        chk("arst_font_col", 32'(font_col), 32'(0));
        chk("arst_font_code", 32'(font_code), 32'(0));
        chk("arst_wr_ready", 32'(wr_if.wr_ready), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        under = 1'b1;
        over  = 1'b0;
        cycle();
        chk("post_reset_out", 32'(col_out), 32'(8'h80));
        chk("post_reset_frame", 32'(frame_start), 32'(1));

        // mixed ring: glyph, raw 0x25, glyph, raw 0x26
        loaded = 0;
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 20 && loaded < 4; i++) begin
            wr_if.wr_data = vals_b[loaded];
            cycle();
            if (m_adv) loaded++;
        end
        wr_if.wr_valid = 1'b0;
        last_frame = -1;
        frame_period = 0;
        nca = 0;
        for (int i = 0; i < 36; i++) begin
            cycle();
            if (col_valid && col_out == 8'hCA) nca++;
        end
        chk("mixed_period", 32'(frame_period), 32'(18));
        chk("raw_ca_count", 32'(nca), 32'(2));

        // clear coinciding with an advance and a pending load
        for (int i = 0; i < 40 && !(m_ring[0][CW] && m_col == 7); i++) cycle();
        chk("pre_clear_col", 32'(font_col), 32'(7));
        clear = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 7'h55;
        cycle();
        clear = 1'b0;
        wr_if.wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/glyph_ring_scroller.md
# glyph_ring_scroller

Parametrised scrolling-text column generator for LED / persistence-of-vision displays. It holds a circular ring of glyph or raw-column words and emits one display column per active cycle. It presents the head word's code and column index to an external font ROM. The ring depth, code width and glyph width are generalised, and the block adds a valid/ready word-load handshake, run/pause, synchronous clear, a registered output with a valid strobe, and a frame-start marker.

## Interface
Parameters:
- WORD_COUNT, 30: ring depth in words (≥2).
- CODE_W, 6: glyph code width. Word width WORD_W = CODE_W+1. Output width DISP_W = CODE_W+2.
- COL_W, 3: column index width. A glyph occupies 2^COL_W columns. COL_MAX = 2^COL_W − 1.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous ring/state clear.
- run  in  1  advance enable.
- wr_valid  in  1  load request.
- wr_data  in  WORD_W  word to load; bit CODE_W = 1 means glyph, 0 means raw column.
- wr_ready  out  1  load accepted this cycle.
- under  in  1  bottom bit for raw columns.
- over  in  1  top bit for raw columns.
- font_code  out  CODE_W  head word code (combinational).
- font_col  out  COL_W  current column index (combinational).
- font_bits  in  DISP_W  font ROM column for (font_code, font_col), combinational, same cycle.
- col_out  out  DISP_W  registered display column.
- col_valid  out  1  col_out updated this cycle.
- frame_start  out  1  registered pulse marking the first column of ring slot 0.

## Operation
- State:
  - ring word[0..WORD_COUNT−1]; word[0] is the head.
  - col counter, COL_W bits.
  - head_idx counter, modulo WORD_COUNT, width clog2(WORD_COUNT).
- head_raw = !word[0][CODE_W]. font_code = word[0][CODE_W−1:0]. font_col = col.
- adv = run && !clear && (head_raw || col == COL_MAX).
- wr_ready = adv (combinational from run/clear and state). A word is accepted when wr_valid && wr_ready.
- On adv:
  - word[i] ← word[i+1] for i < WORD_COUNT−1.
  - word[WORD_COUNT−1] ← wr_valid ? wr_data : word[0]. The outgoing head is discarded when a load is accepted, and recirculates otherwise.
  - col ← 0.
  - head_idx ← (head_idx == WORD_COUNT−1) ? 0 : head_idx+1.
- On run && !adv && !clear: col ← col+1. Ring and head_idx hold.
- run=0: ring, col and head_idx hold; wr_ready=0.
- Raw words display for exactly one column; glyph words display for 2^COL_W columns.
- Output register, when run && !clear:
  - col_out ← head_raw ? {under, word[0][CODE_W−1:0], over} : font_bits.
  - col_valid ← 1.
  - frame_start ← (head_idx == 0 && col == 0).
- Output register, otherwise: col_out holds; col_valid ← 0; frame_start ← 0.
- clear (highest priority below reset):
  - all words ← 0, col ← 0, head_idx ← 0.
  - col_valid ← 0, frame_start ← 0; col_out holds.
  - wr_ready = 0, so a simultaneous wr_valid is dropped.
- head_idx counts rotations, not load position. After a full lap, slot 0 is whatever word currently sits at the ring position loaded WORD_COUNT rotations earlier.

## Timing
- Reset values: all words 0 (raw, code 0), col=0, head_idx=0, col_out=0, col_valid=0, frame_start=0. wr_ready=0 while reset is asserted.
- Reset deasserted mid-operation: all state restarts from the values above; no partial rotation is retained.
- Latency: col_out/col_valid/frame_start appear 1 cycle after the font_code/font_col/font_bits cycle they reflect.
- Handshake: wr_ready may rise without wr_valid, and its rise is not registered. wr_valid may stay high across cycles; exactly one word is taken per adv cycle. A word presented while wr_ready=0 is not consumed.
- Wrap: col wraps COL_MAX→0 only through adv. head_idx wraps WORD_COUNT−1→0.
- Frame period, all glyphs: WORD_COUNT·2^COL_W run cycles.
- Frame period, mixed: Σ(glyph words)·2^COL_W + (raw words) run cycles.

## Test plan
- Async reset mid-run: assert reset between clock edges while col=5 → all outputs 0 immediately. After release with run=1, the first col_valid=1 carries col_out = {under,000000,over} and frame_start=1.
- Load: WORD_COUNT=4, COL_W=3, run=1, stream glyph words 0x41..0x44 on each wr_ready → font_code cycles 0x01,0x02,0x03,0x04 every 8 cycles. Afterwards it recirculates with wr_valid=0; frame_start period is 32.
- Raw column: head word 0x25, under=1, over=0 → col_out=8'hCA for exactly one col_valid cycle, then adv.
- Pause: run=0 for 5 cycles with font_col=3 → col_valid=0 and font_col stays 3. Resume continues at column 3→4.
- Clear with wr_valid=1 at an adv cycle → wr_ready=0, word dropped. Next cycle head_idx=0, col=0, all words raw 0.
- Mixed frame: ring {glyph, raw, glyph, raw}, COL_W=3 → frame_start pulses every 18 run cycles.
